// File: rtl/fetch_queue.sv
// Fetch stage with a DEPTH-entry prefetch queue between instruction memory and decode.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter int              TAG_WIDTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 jump,
  input  logic [XLEN-1:0]      jump_target,
  output logic                 i_req,
  output logic [XLEN-1:0]      i_address,
  input  logic                 i_gnt,
  input  logic [31:0]          instruction,
  input  logic                 stall,
  output logic                 valid_out,
  output logic [31:0]          IR,
  output logic [XLEN-1:0]      NPC,
  output logic [TAG_WIDTH-1:0] tag_out,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // Handshakes: a request transfers on a cycle with i_req & i_gnt and its data
  // arrives exactly one cycle later; decode takes the head on valid_out & ~stall.
  logic [XLEN-1:0]      r_pc;
  logic [XLEN-1:0]      r_resp_addr;
  logic                 r_inflight;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [31:0]          r_q_ir  [DEPTH];
  logic [XLEN-1:0]      r_q_npc [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;

  logic [AW:0] w_occupancy;
  logic        w_empty;
  logic        w_issue;
  logic        w_grant;
  logic        w_resp;
  logic        w_bypass;
  logic        w_pop;
  logic        w_push;

  // Occupancy counts the outstanding request so a response always has a free slot.
  assign w_occupancy = r_count + {{AW{1'b0}}, r_inflight};
  assign w_empty     = (r_count == '0);
  assign w_issue     = reset & ~jump & (w_occupancy < DEPTH_C);
  assign w_grant     = w_issue & i_gnt;
  assign w_resp      = r_inflight & ~jump;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_empty & w_resp;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_pop  = ~w_empty & ~stall & ~jump;
  assign w_push = w_resp & ~(w_bypass & ~stall);

  assign i_req     = w_issue;
  assign i_address = r_pc;
  assign tag_out   = r_tag;
  assign empty     = w_empty;
  assign valid_out = ~w_empty | w_bypass;

  always_comb begin
    IR  = '0;
    NPC = '0;
    if (!w_empty) begin
      IR  = r_q_ir[r_rd_ptr];
      NPC = r_q_npc[r_rd_ptr];
    end else if (w_bypass) begin
      IR  = instruction;
      NPC = r_resp_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_ir[r_wr_ptr]  <= instruction;
      r_q_npc[r_wr_ptr] <= r_resp_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_PC;
      r_resp_addr <= '0;
      r_inflight  <= 1'b0;
      r_tag       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else if (jump) begin
      r_pc       <= jump_target;
      r_tag      <= r_tag + 1'b1;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_grant;
      if (w_grant) begin
        r_pc        <= r_pc + XLEN'(4);
        r_resp_addr <= r_pc;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, back-pressure, grant gaps, jumps, tag wrap, mid-run reset.
module tb_fetch_queue;

  localparam int XLEN      = 32;
  localparam int DEPTH     = 4;
  localparam int TAG_WIDTH = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 jump = 1'b0;
  logic [XLEN-1:0]      jump_target = '0;
  logic                 i_req;
  logic [XLEN-1:0]      i_address;
  logic                 i_gnt = 1'b0;
  logic [31:0]          instruction = '0;
  logic                 stall = 1'b0;
  logic                 valid_out;
  logic [31:0]          IR;
  logic [XLEN-1:0]      NPC;
  logic [TAG_WIDTH-1:0] tag_out;
  logic                 empty;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .jump(jump), .jump_target(jump_target),
    .i_req(i_req), .i_address(i_address), .i_gnt(i_gnt), .instruction(instruction),
    .stall(stall), .valid_out(valid_out), .IR(IR), .NPC(NPC),
    .tag_out(tag_out), .empty(empty)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hC3, a[23:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs change at the falling edge, outputs are checked by the caller afterwards.
  task automatic drive(input logic g, input logic s, input logic j, input logic [31:0] t);
    @(negedge clk);
    instruction = pend ? mem_word(pend_addr) : 32'h0;
    i_gnt       = g;
    stall       = s;
    jump        = j;
    jump_target = t;
    #1;
    pend      = i_req & i_gnt;
    pend_addr = i_address;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   i_req,     0);
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_empty"}, empty,     1);
    chk({tag, "_ir"},    IR,        0);
    chk({tag, "_npc"},   NPC,       0);
    chk({tag, "_tag"},   tag_out,   0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; i_gnt = 1'b0; stall = 1'b0; jump = 1'b0; instruction = '0; pend = 1'b0;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int grants;
    logic exp_valid;

    // streaming from reset: grant N -> valid N+2
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 0, 0);
      chk("stream_addr", i_address, 32'(4 * k));
      chk("stream_valid", valid_out, (k >= 2) ? 1 : 0);
      if (k >= 2) begin
        chk("stream_npc", NPC, 32'(4 * (k - 2)));
        chk("stream_ir", IR, mem_word(32'(4 * (k - 2))));
      end
    end

    // held stall fills exactly DEPTH entries
    do_reset();
    grants = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, 0, 0);
      grants += int'(pend);
    end
    chk("fill_grants", grants, 4);
    chk("fill_req", i_req, 0);
    chk("fill_valid", valid_out, 1);
    chk("fill_empty", empty, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 0);
      chk("drain_valid", valid_out, 1);
      chk("drain_npc", NPC, 32'(4 * k));
      chk("drain_ir", IR, mem_word(32'(4 * k)));
    end

    // grant toggling 1,0,1,0
    do_reset();
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC};
    for (int k = 0; k < 10; k++) begin
      drive((k % 2) == 0, 0, 0, 0);
      chk("gap_addr", i_address, 32'(4 * ((k + 1) / 2)));
      exp_valid = (k >= 2) && ((k % 2) == 0);
      chk("gap_valid", valid_out, exp_valid);
      if (exp_valid) chk("gap_npc", NPC, exp_q.pop_front());
    end

    // jump with 3 queued entries and one response in flight
    do_reset();
    for (int k = 0; k < 4; k++) drive(1, 1, 0, 0);
    chk("pre_jump_tag", tag_out, 0);
    chk("pre_jump_valid", valid_out, 1);
    drive(1, 1, 1, 32'h100);
    chk("jump_req", i_req, 0);
    drive(1, 0, 0, 0);
    chk("post_jump_valid", valid_out, 0);
    chk("post_jump_empty", empty, 1);
    chk("post_jump_tag", tag_out, 1);
    chk("post_jump_req", i_req, 1);
    chk("post_jump_addr", i_address, 32'h100);
    drive(1, 0, 0, 0);
    chk("post_jump_valid2", valid_out, 0);
    chk("post_jump_addr2", i_address, 32'h104);
    drive(1, 0, 0, 0);
    chk("post_jump_valid3", valid_out, 1);
    chk("post_jump_npc", NPC, 32'h100);
    chk("post_jump_ir", IR, mem_word(32'h100));

    // 16 consecutive jumps: tag wraps, last target wins
    for (int j = 0; j < 16; j++) begin
      drive(1, 0, 1, 32'(32'h200 + 16 * j));
      chk("jumps_req", i_req, 0);
      chk("jumps_tag", tag_out, 32'((1 + j) % 16));
    end
    drive(1, 0, 0, 0);
    chk("jumps_final_tag", tag_out, 1);
    chk("jumps_final_addr", i_address, 32'h2F0);
    chk("jumps_final_valid", valid_out, 0);

    // fill, then assert reset asynchronously mid-cycle
    for (int k = 0; k < 6; k++) drive(1, 1, 0, 0);
    chk("full_req", i_req, 0);
    chk("full_valid", valid_out, 1);
    chk("full_npc", NPC, 32'h2F0);
    chk("full_tag", tag_out, 1);
    #1 reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b1;
    pend  = 1'b0;
    i_gnt = 1'b0;
    stall = 1'b0;
    drive(1, 0, 0, 0);
    chk("restart_req", i_req, 1);
    chk("restart_addr", i_address, 0);
    chk("restart_tag", tag_out, 0);
    drive(1, 0, 0, 0);
    chk("restart_addr2", i_address, 4);
    drive(1, 0, 0, 0);
    chk("restart_valid", valid_out, 1);
    chk("restart_npc", NPC, 0);
    chk("restart_ir", IR, mem_word(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised next-generation fetch stage: decouples instruction memory from decode with a DEPTH-entry prefetch queue.
- Issues sequential instruction requests over a req/gnt handshake and presents instructions to decode with valid/stall flow control.
- On a taken jump from retire it flushes the queue and redirects the PC.
- Carries the tag used by decode and retire to kill wrong-path instructions.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 4, queue entries; power of two, >=2.
- TAG_WIDTH, 4, instruction tag width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- jump  in  1  taken redirect from retire.
- jump_target  in  XLEN  redirect address.
- i_req  out  1  fetch request valid.
- i_address  out  XLEN  fetch address, word aligned.
- i_gnt  in  1  memory accepted request this cycle.
- instruction  in  32  memory data, valid exactly 1 cycle after grant.
- stall  in  1  decode cannot accept (bubble).
- valid_out  out  1  IR/NPC/tag_out hold a valid instruction.
- IR  out  32  instruction at queue head.
- NPC  out  XLEN  address of that instruction.
- tag_out  out  TAG_WIDTH  current tag.
- empty  out  1  queue empty.

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, queue empty, inflight=0, tag=0. Outputs: i_req=0, valid_out=0, IR=0, NPC=0, tag_out=0, empty=1.
- Issue: i_req = (count + inflight < DEPTH) & ~jump; i_address = pc.
  - On i_req & i_gnt: pc += 4 (wraps modulo 2^XLEN), inflight=1.
  - i_gnt=0: pc holds and the request repeats next cycle.
- Response: in the cycle after a grant, {instruction, request address} is enqueued at the tail; inflight clears unless a new grant occurs in the same cycle.
- Dequeue: when valid_out & ~stall, the head is popped at the clock edge.
- Simultaneous push and pop: count unchanged; push into a full queue cannot occur because of the issue rule.
- Pointers: log2(DEPTH)-bit, wrap naturally; count is log2(DEPTH)+1 bits; full when count==DEPTH.
- Latency, no bypass: grant in cycle N, valid_out in N+2. Steady state is 1 instruction/cycle when gnt=1 and stall=0.
- Jump (highest priority):
  - That cycle: i_req=0, the arriving response is discarded, no pop occurs.
  - Next edge: queue emptied, inflight=0, pc=jump_target, tag=tag+1 (wraps modulo 2^TAG_WIDTH).
  - First post-jump request in the following cycle.
- Jump with a full queue and stall=1: flush still occurs. Consecutive jumps: each increments the tag; the last target wins.
- valid_out = ~empty; IR/NPC show the head entry. When empty: IR=0 and NPC=0, unless FETCH_BYPASS_EN bypasses.
- stall has no effect on issue except through occupancy.
- reset asserted mid-operation returns everything to reset values immediately; no request is outstanding after deassertion.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the queue is empty, a valid response arrives and jump=0, the response drives IR/NPC with valid_out=1 in the same cycle.
  - If stall=0, it is consumed and not enqueued; if stall=1, it is enqueued normally.
  - Latency becomes grant N, valid_out N+1.
- Undefined: no bypass; latency N+2.

Test Plan:
- Reset release, RESET_PC=0, gnt=1, stall=0 -> i_address 0,4,8,... on consecutive cycles. valid_out first high 2 cycles after the first grant (1 with FETCH_BYPASS_EN). NPC=0 with IR = word at 0.
- stall=1 held, gnt=1, DEPTH=4 -> exactly 4 grants, then i_req=0; count=4. Release stall -> NPC sequence 0,4,8,12,16 with no gap or duplicate.
- gnt toggling 1,0,1,0 -> i_address repeats on non-granted cycles; no instruction lost or duplicated; NPC strictly +4.
- jump=1, target 0x100, while queue holds 3 entries and a response is in flight -> next cycle valid_out=0 and tag_out=old+1. First i_address=0x100 one cycle after the jump; no pre-jump instruction ever appears.
- 16 jumps with TAG_WIDTH=4 -> tag_out wraps 15->0.
- Assert reset mid-stream with the queue full -> valid_out=0, i_req=0, empty=1 immediately. After release, fetch restarts at RESET_PC with tag 0.
